mem_bus_arbiter: RTL and testbench

- Shares one unified memory bus between the fetch stage (instruction reads) and the mem_access stage (data reads/writes) of the 5-stage RV32I core.
- Sits between the core's fetch/mem_access request signals and the external memory port.
- Serializes requests through a small FSM and returns per-requester active-low ready pulses, so the hazard/stall logic can treat both sides like independent buses.
- Data side has priority; an optional fairness counter prevents fetch starvation.

---
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the fetch and mem_access
// stages. Data has priority over fetch; ARB_FAIR_EN adds a starvation
// counter that forces fetch through after STARVE_LIMIT data grants.
// Ports: clk/rst; fetch side i_req/i_addr -> i_rdata/i_ready_n;
// data side d_req/d_write/d_size/d_addr/d_wdata -> d_rdata/d_ready_n;
// memory side m_req/m_write/m_size/m_addr/m_wdata/m_owner <- m_rdata,
// m_ready_n, m_busy. Ready outputs are active-low one-cycle pulses.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready_n,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready_n,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready_n,
  input  logic        m_busy,
  output logic        m_owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS_I,
    S_BUS_D,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_m_req;
  logic        r_m_write;
  logic [1:0]  r_m_size;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic        r_m_owner;
  logic        r_i_ready_n;
  logic        r_d_ready_n;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;

  logic w_force;
  logic w_grant_d;
  logic w_grant_i;

`ifdef ARB_FAIR_EN
  logic [CNT_W-1:0] r_starve;

  assign w_force = (r_starve == CNT_W'(STARVE_LIMIT)) && i_req;

  // Counts data grants that made a waiting fetch wait longer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_grant_i) begin
      r_starve <= '0;
    end else if (w_grant_d && i_req &&
                 (r_starve != CNT_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  logic w_unused_params;

  assign w_force         = 1'b0;
  assign w_unused_params = |{STARVE_LIMIT, CNT_W};
`endif

  // Grants only happen from IDLE with the bus willing to accept.
  assign w_grant_d = (r_state == S_IDLE) && !m_busy &&
                     d_req && !w_force;
  assign w_grant_i = (r_state == S_IDLE) && !m_busy &&
                     !w_grant_d && i_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_m_req     <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_size    <= 2'b00;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_m_owner   <= 1'b0;
      r_i_ready_n <= 1'b1;
      r_d_ready_n <= 1'b1;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state   <= S_BUS_D;
            r_m_req   <= 1'b1;
            r_m_write <= d_write;
            r_m_size  <= d_size;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_owner <= 1'b1;
          end else if (w_grant_i) begin
            r_state   <= S_BUS_I;
            r_m_req   <= 1'b1;
            r_m_write <= 1'b0;
            r_m_size  <= 2'b10;
            r_m_addr  <= i_addr;
            r_m_wdata <= '0;
            r_m_owner <= 1'b0;
          end
        end
        S_BUS_I: begin
          if (!m_ready_n) begin
            r_i_rdata   <= m_rdata;
            r_m_req     <= 1'b0;
            r_m_write   <= 1'b0;
            r_i_ready_n <= 1'b0;
            r_state     <= S_RESP;
          end
        end
        S_BUS_D: begin
          if (!m_ready_n) begin
            r_d_rdata   <= m_rdata;
            r_m_req     <= 1'b0;
            r_m_write   <= 1'b0;
            r_d_ready_n <= 1'b0;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_i_ready_n <= 1'b1;
          r_d_ready_n <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_req     = r_m_req;
  assign m_write   = r_m_write;
  assign m_size    = r_m_size;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign m_owner   = r_m_owner;
  assign i_ready_n = r_i_ready_n;
  assign d_ready_n = r_d_ready_n;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench with a transaction-level model of
// the arbiter checked every cycle, plus literal spot checks.
module tb_mem_bus_arbiter;

`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready_n;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready_n;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready_n;
  logic        m_busy;
  logic        m_owner;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_ready_n(i_ready_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready_n(d_ready_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready_n(m_ready_n),
    .m_busy(m_busy), .m_owner(m_owner)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h100) return 32'h13;
    return (a ^ 32'h5A5A_0000) + 32'd7;
  endfunction

  // Memory: completes lat cycles after m_req is first seen.
  int lat = 0;
  int mw  = 0;
  always @(posedge clk) begin
    #1;
    if (!m_req) begin
      mw        = 0;
      m_ready_n = 1'b1;
    end else if (mw >= lat) begin
      m_ready_n = 1'b0;
      m_rdata   = memfn(m_addr);
    end else begin
      mw++;
      m_ready_n = 1'b1;
    end
  end

  // Owner of every grant seen on the bus (m_req rising).
  int glog[$];
  bit prev_mreq = 1'b0;

  // Transaction-level model state.
  bit          have_snap = 1'b0;
  bit          s_rst, s_ireq, s_dreq, s_busy, s_mrdy, s_dwrite;
  logic [1:0]  s_dsize;
  logic [31:0] s_iaddr, s_daddr, s_dwdata, s_mrdata;
  bit          e_active = 1'b0;
  bit          e_resp   = 1'b0;
  bit          e_own    = 1'b0;
  bit          e_write  = 1'b0;
  logic [1:0]  e_size   = 2'b00;
  logic [31:0] e_addr   = '0;
  logic [31:0] e_wdata  = '0;
  logic [31:0] e_irdata = '0;
  logic [31:0] e_drdata = '0;
  int          e_cnt    = 0;

  always @(negedge clk) begin
    if (have_snap) begin
      if (s_rst) begin
        e_active = 0; e_resp = 0; e_own = 0; e_write = 0;
        e_size = 0; e_addr = 0; e_wdata = 0;
        e_irdata = 0; e_drdata = 0; e_cnt = 0;
      end else if (e_resp) begin
        e_resp = 0;
      end else if (e_active) begin
        if (!s_mrdy) begin
          if (e_own) e_drdata = s_mrdata;
          else e_irdata = s_mrdata;
          e_active = 0;
          e_resp   = 1;
        end
      end else if (!s_busy) begin
        if (s_dreq && !(FAIR && e_cnt == LIMIT && s_ireq)) begin
          e_active = 1; e_own = 1; e_write = s_dwrite;
          e_size = s_dsize; e_addr = s_daddr; e_wdata = s_dwdata;
          if (s_ireq && e_cnt < LIMIT) e_cnt++;
        end else if (s_ireq) begin
          e_active = 1; e_own = 0; e_write = 0;
          e_size = 2'b10; e_addr = s_iaddr; e_wdata = 0;
          e_cnt = 0;
        end
      end
      chk("ctl {req,wr,size,own,irdy,drdy}",
          {m_req, m_write, m_size, m_owner, i_ready_n, d_ready_n},
          {e_active, e_active & e_write, e_size, e_own,
           !(e_resp && !e_own), !(e_resp && e_own)});
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
      chk("i_rdata", i_rdata, e_irdata);
      chk("d_rdata", d_rdata, e_drdata);
    end
    if (m_req && !prev_mreq) glog.push_back(int'(m_owner));
    prev_mreq = m_req;
    s_rst = rst; s_ireq = i_req; s_dreq = d_req; s_busy = m_busy;
    s_mrdy = m_ready_n; s_mrdata = m_rdata; s_iaddr = i_addr;
    s_dwrite = d_write; s_dsize = d_size; s_daddr = d_addr;
    s_dwdata = d_wdata;
    have_snap = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Waits for the ready pulse of one side, then drops that request.
  task automatic run(input bit side, output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (side ? !d_ready_n : !i_ready_n) begin
        ok  = 1'b1;
        cyc = k + 1;
        break;
      end
    end
    if (side) d_req = 1'b0;
    else i_req = 1'b0;
    chk("ready pulse seen before timeout", 32'(ok), 32'd1);
  endtask

  int cyc;
  int exp_order[10];

  initial begin
    rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_write = 0;
    d_size = 0; d_addr = 0; d_wdata = 0; m_busy = 0;
    m_ready_n = 1; m_rdata = 0;
    repeat (3) step();
    chk("reset i_ready_n", 32'(i_ready_n), 32'd1);
    chk("reset m_req", 32'(m_req), 32'd0);
    rst = 0;
    step();

    // Reset while a data cycle is on the bus.
    lat = 3;
    d_req = 1; d_write = 0; d_size = 2'b10; d_addr = 32'h3000;
    step();
    chk("pre-reset m_req", 32'(m_req), 32'd1);
    rst = 1;
    step();
    chk("post-reset m_req", 32'(m_req), 32'd0);
    chk("post-reset d_ready_n", 32'(d_ready_n), 32'd1);
    rst = 0; d_req = 0;
    step();

    // Single fetch.
    lat = 0;
    i_req = 1; i_addr = 32'h100;
    run(1'b0, cyc);
    chk("fetch latency", 32'(cyc), 32'd2);
    chk("fetch i_rdata", i_rdata, 32'h13);
    chk("fetch m_addr", m_addr, 32'h100);
    chk("fetch m_size", 32'(m_size), 32'd2);
    step();
    chk("fetch pulse width", 32'(i_ready_n), 32'd1);

    // Store.
    lat = 2;
    d_req = 1; d_write = 1; d_size = 2'b00;
    d_addr = 32'h2003; d_wdata = 32'hAB;
    run(1'b1, cyc);
    chk("store latency", 32'(cyc), 32'd4);
    chk("store m_addr", m_addr, 32'h2003);
    chk("store m_wdata", m_wdata, 32'hAB);
    chk("store m_owner", 32'(m_owner), 32'd1);
    step();

    // Contention: data first, then fetch.
    lat = 0;
    glog.delete();
    d_write = 0; d_size = 2'b10; d_addr = 32'h2000;
    i_addr = 32'h104;
    i_req = 1; d_req = 1;
    for (int k = 0; k < 40 && i_req; k++) begin
      step();
      if (!d_ready_n) d_req = 0;
      if (!i_ready_n) i_req = 0;
    end
    chk("contention grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("contention first owner", 32'(glog[0]), 32'd1);
      chk("contention second owner", 32'(glog[1]), 32'd0);
    end
    chk("contention i_rdata", i_rdata, 32'h5A5A_010B);
    step();

    // Busy memory holds off the grant.
    d_req = 1; d_addr = 32'h40; m_busy = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("busy m_req", 32'(m_req), 32'd0);
    end
    m_busy = 0;
    step();
    chk("busy release m_req", 32'(m_req), 32'd1);
    run(1'b1, cyc);
    chk("busy d_rdata", d_rdata, 32'h5A5A_0047);
    step();

    // Both requests held continuously.
    glog.delete();
    d_addr = 32'h80; i_addr = 32'h200;
    i_req = 1; d_req = 1;
    repeat (40) step();
    i_req = 0; d_req = 0;
    repeat (6) step();
    if (FAIR) exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    else exp_order = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    chk("held grants >= 10", 32'(glog.size() >= 10), 32'd1);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk($sformatf("held grant %0d owner", k),
          32'(glog[k]), 32'(exp_order[k]));

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
